// File: rtl/mem_bist_1r1w_if.sv
// Memory-side bus of the 1R1W BIST: one read port, one byte-enabled write port.
// master = BIST initiator, slave = memory instance.
interface mem_bist_1r1w_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_BYTES = 8
);
  logic                      mem_re;
  logic [ADDR_WIDTH-1:0]     mem_rd_addr;
  logic [8*WORD_BYTES-1:0]   mem_rd_data;
  logic                      mem_we;
  logic [ADDR_WIDTH-1:0]     mem_wr_addr;
  logic [8*WORD_BYTES-1:0]   mem_wr_data;
  logic [WORD_BYTES-1:0]     mem_be;

  modport master (
    output mem_re, mem_rd_addr, mem_we, mem_wr_addr, mem_wr_data, mem_be,
    input  mem_rd_data
  );

  modport slave (
    input  mem_re, mem_rd_addr, mem_we, mem_wr_addr, mem_wr_data, mem_be,
    output mem_rd_data
  );
endinterface

// File: rtl/mem_bist_1r1w.sv
// March BIST for a 1R1W memory: M0 up w0, M1 up r0/w1, M2 down r1/w0, M3 up r0.
// Reports pass/fail plus the address and element of the first mismatch.
module mem_bist_1r1w #(
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int WORD_BYTES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [1:0]            fail_elem,
  mem_bist_1r1w_if.master       mem
);

  localparam int DATA_WIDTH = 8 * WORD_BYTES;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  typedef enum logic [3:0] {
    IDLE, M0_W, M1_RD, M1_CW, M2_RD, M2_CW, M3_RD, M3_C, DONE
  } state_t;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] expected;
  logic                  rd_match;
  logic                  wr_en;

  // Expected read pattern per compare state; only M2 expects all ones.
  always_comb begin
    expected = (state_reg == M2_CW) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
    rd_match = (mem.mem_rd_data == expected);
    // The read-then-write elements write in the compare cycle itself, and only
    // when the compare matched, so this enable cannot come from a register.
    wr_en    = (state_reg == M0_W) ||
               (((state_reg == M1_CW) || (state_reg == M2_CW)) && rd_match);
  end

  // Memory port decode from the state/address registers; async reset of those
  // registers forces every memory output to zero immediately.
  assign mem.mem_re      = (state_reg == M1_RD) || (state_reg == M2_RD) || (state_reg == M3_RD);
  assign mem.mem_rd_addr = addr_reg;
  assign mem.mem_we      = wr_en;
  assign mem.mem_wr_addr = addr_reg;
  assign mem.mem_wr_data = (state_reg == M1_CW) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
  assign mem.mem_be      = wr_en ? {WORD_BYTES{1'b1}} : {WORD_BYTES{1'b0}};

  // March sequencer with registered status outputs; a mismatch aborts to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= 2'd0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg <= M0_W;
            addr_reg  <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= 2'd0;
          end
        end
        M0_W: begin
          if (addr_reg == LAST_ADDR) begin
            state_reg <= M1_RD;
            addr_reg  <= '0;
          end else begin
            addr_reg  <= addr_reg + 1'b1;
          end
        end
        M1_RD: state_reg <= M1_CW;
        M1_CW: begin
          if (!rd_match) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail_addr <= addr_reg;
            fail_elem <= 2'd1;
          end else if (addr_reg == LAST_ADDR) begin
            state_reg <= M2_RD;
          end else begin
            state_reg <= M1_RD;
            addr_reg  <= addr_reg + 1'b1;
          end
        end
        M2_RD: state_reg <= M2_CW;
        M2_CW: begin
          if (!rd_match) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail_addr <= addr_reg;
            fail_elem <= 2'd2;
          end else if (addr_reg == '0) begin
            state_reg <= M3_RD;
          end else begin
            state_reg <= M2_RD;
            addr_reg  <= addr_reg - 1'b1;
          end
        end
        M3_RD: state_reg <= M3_C;
        M3_C: begin
          if (!rd_match) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail_addr <= addr_reg;
            fail_elem <= 2'd3;
          end else if (addr_reg == LAST_ADDR) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= 1'b1;
          end else begin
            state_reg <= M3_RD;
            addr_reg  <= addr_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
